// File: rtl/qam_demap_pack.sv
// Hard-decision QPSK/16-QAM/64-QAM demapper with Gray slicing.
// Packs variable-length symbol bit groups into OUT_W-bit words.
module qam_demap_pack #(
  parameter int IN_W  = 11,
  parameter int STEP  = 16,
  parameter int OUT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   valid_i,
  output logic                   ready_i,
  input  logic [1:0]             mode_i,
  input  logic signed [IN_W-1:0] ar,
  input  logic signed [IN_W-1:0] ai,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_o,
  output logic [OUT_W-1:0]       data_o,
  output logic [3:0]             nbits_o,
  output logic                   last_o,
  output logic                   err_o
);

  localparam int AW = 2 * OUT_W;
  localparam int CW = $clog2(AW + 1);

  localparam logic [IN_W-1:0] T1 = IN_W'(STEP);
  localparam logic [IN_W-1:0] T2 = IN_W'(2 * STEP);
  localparam logic [IN_W-1:0] T3 = IN_W'(3 * STEP);
  localparam logic [CW-1:0]   OW = CW'(OUT_W);
  localparam logic [CW-1:0]   RMAX = CW'(AW - 6);

  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_n;
  logic [AW-1:0]   base;
  logic [AW-1:0]   ins;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   cbase;
  logic [CW-1:0]   take;
  logic [CW-1:0]   nb;
  logic            flush_pend;
  logic            fp_n;
  logic [5:0]      sym;
  logic            rsvd;
  logic            accept;
  logic            pop;

  logic            r_neg;
  logic            i_neg;
  logic [IN_W-1:0] r_m;
  logic [IN_W-1:0] i_m;
  logic            r_b1q;
  logic            i_b1q;
  logic            r_b1s;
  logic            i_b1s;
  logic            r_b0;
  logic            i_b0;

  // One's-complement folding makes -STEP land inside, +STEP outside
  always_comb begin
    r_neg = ar[IN_W-1];
    i_neg = ai[IN_W-1];
    r_m   = ar ^ {IN_W{r_neg}};
    i_m   = ai ^ {IN_W{i_neg}};
    r_b1q = r_m < T1;
    i_b1q = i_m < T1;
    r_b1s = r_m < T2;
    i_b1s = i_m < T2;
    r_b0  = (r_m >= T1) && (r_m < T3);
    i_b0  = (i_m >= T1) && (i_m < T3);
  end

  // Symbol word and its bit count for the requested modulation
  always_comb begin
    sym  = '0;
    nb   = '0;
    rsvd = 1'b0;
    unique case (mode_i)
      2'b00: begin
        sym = {4'b0, r_neg, i_neg};
        nb  = CW'(2);
      end
      2'b01: begin
        sym = {2'b0, r_neg, i_neg, r_b1q, i_b1q};
        nb  = CW'(4);
      end
      2'b10: begin
        sym = {r_neg, i_neg, r_b1s, i_b1s, r_b0, i_b0};
        nb  = CW'(6);
      end
      default: rsvd = 1'b1;
    endcase
  end

  // Handshake status, decoded only from registered state
  always_comb begin
    ready_i = !flush_pend && (cnt <= RMAX);
    valid_o = (cnt >= OW) || (flush_pend && (cnt != '0));
    take    = (cnt >= OW) ? OW : cnt;
    nbits_o = 4'(take);
    last_o  = flush_pend && valid_o && (cnt <= OW);
    accept  = valid_i && ready_i;
    pop     = valid_o && ready_o;
    data_o  = '0;
    for (int k = 0; k < OUT_W; k++) begin
      data_o[k] = acc[k] & (CW'(k) < take);
    end
  end

  // Shift out a popped word first, then append new symbol bits
  always_comb begin
    base  = pop ? (acc >> OUT_W) : acc;
    cbase = pop ? (cnt - take) : cnt;
    ins   = AW'(sym) << cbase;
    acc_n = accept ? (base | ins) : base;
    cnt_n = accept ? (cbase + nb) : cbase;
    fp_n  = flush_pend;
    if (flush_i) begin
      fp_n = 1'b1;
    end else if (flush_pend && (cnt_n == '0)) begin
      fp_n = 1'b0;
    end
  end

  // Packer state and sticky reserved-mode flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_pend <= fp_n;
      if (accept && rsvd) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam_demap_pack.sv
// Self-checking bench for qam_demap_pack.
// Directed scenarios plus randomized traffic against a bit-queue model.
module tb_qam_demap_pack;

  localparam int IN_W  = 11;
  localparam int STEP  = 16;
  localparam int OUT_W = 8;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   valid_i = 1'b0;
  logic                   ready_i;
  logic [1:0]             mode_i = 2'b00;
  logic signed [IN_W-1:0] ar = '0;
  logic signed [IN_W-1:0] ai = '0;
  logic                   flush_i = 1'b0;
  logic                   valid_o;
  logic                   ready_o = 1'b0;
  logic [OUT_W-1:0]       data_o;
  logic [3:0]             nbits_o;
  logic                   last_o;
  logic                   err_o;

  int errs = 0;
  int checks = 0;

  bit mq[$];
  bit mfp;
  bit merr;

  qam_demap_pack #(.IN_W(IN_W), .STEP(STEP), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .ready_i(ready_i),
    .mode_i(mode_i), .ar(ar), .ai(ai), .flush_i(flush_i),
    .valid_o(valid_o), .ready_o(ready_o), .data_o(data_o),
    .nbits_o(nbits_o), .last_o(last_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    flush_i = 1'b0;
    mode_i  = 2'b00;
    ar      = '0;
    ai      = '0;
  endtask

  task automatic send(input logic [1:0] m, input int r, input int i);
    valid_i = 1'b1;
    mode_i  = m;
    ar      = IN_W'(r);
    ai      = IN_W'(i);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    ready_o = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Reference slicer: thresholds applied to the folded magnitude
  function automatic void ref_sym(input int md, input int r, input int i,
                                  output int nb, output int w);
    int mr;
    int mi;
    int rn;
    int ineg;
    rn   = int'(r < 0);
    ineg = int'(i < 0);
    mr   = (r < 0) ? -r - 1 : r;
    mi   = (i < 0) ? -i - 1 : i;
    case (md)
      0: begin
        nb = 2;
        w  = rn * 2 + ineg;
      end
      1: begin
        nb = 4;
        w  = rn * 8 + ineg * 4 + int'(mr < STEP) * 2 + int'(mi < STEP);
      end
      2: begin
        nb = 6;
        w  = rn * 32 + ineg * 16 + int'(mr < 2 * STEP) * 8
           + int'(mi < 2 * STEP) * 4
           + int'(mr >= STEP && mr < 3 * STEP) * 2
           + int'(mi >= STEP && mi < 3 * STEP);
      end
      default: begin
        nb = 0;
        w  = 0;
      end
    endcase
  endfunction

  // Advance the queue model across one clock edge
  task automatic model_edge(input bit vi, input int md, input int r,
                            input int i, input bit fl, input bit ro,
                            input bit ev, input bit er);
    int nb;
    int w;
    int n;
    if (ev && ro) begin
      n = (mq.size() < OUT_W) ? mq.size() : OUT_W;
      repeat (n) void'(mq.pop_front());
    end
    if (vi && er) begin
      if (md == 3) merr = 1'b1;
      ref_sym(md, r, i, nb, w);
      for (int k = 0; k < nb; k++) mq.push_back(bit'((w >> k) & 1));
    end
    if (fl) mfp = 1'b1;
    else if (mfp && mq.size() == 0) mfp = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i, data_o, nbits_o, last_o, err_o} !==
        {1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_state got v=%b r=%b d=%h n=%0d l=%b e=%b want v=0 r=1 d=00 n=0 l=0 e=0",
               valid_o, ready_i, data_o, nbits_o, last_o, err_o);
    end
  endtask

  task automatic test_order();
    do_reset();
    ready_o = 1'b1;
    send(2'b01, 20, 5);
    @(negedge CLK);
    checks++;
    if (valid_o !== 1'b0) begin
      errs++;
      $display("FAIL order_early_valid got %b want 0", valid_o);
    end
    tick();
    send(2'b01, -16, -3);
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, nbits_o, last_o} !== {1'b1, 8'hF1, 4'd8, 1'b0}) begin
      errs++;
      $display("FAIL order_word got v=%b d=%h n=%0d l=%b want v=1 d=f1 n=8 l=0",
               valid_o, data_o, nbits_o, last_o);
    end
    tick();
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i} !== 2'b01) begin
      errs++;
      $display("FAIL order_after_pop got v=%b r=%b want v=0 r=1", valid_o, ready_i);
    end
  endtask

  task automatic test_mixed();
    do_reset();
    ready_o = 1'b1;
    send(2'b10, 50, -20);
    send(2'b00, -1, 0);
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, nbits_o} !== {1'b1, 8'h95, 4'd8}) begin
      errs++;
      $display("FAIL mixed_word got v=%b d=%h n=%0d want v=1 d=95 n=8",
               valid_o, data_o, nbits_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int rs[6];
    int is[6];
    logic [7:0] w1;
    logic [7:0] w2;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rs[k] = int'($urandom_range(0, 2000)) - 1000;
      is[k] = int'($urandom_range(0, 2000)) - 1000;
    end
    w1 = '0;
    w2 = '0;
    for (int k = 0; k < 4; k++) begin
      w1[2*k]   = rs[k] < 0 ? 1'b0 : 1'b0;
      w1[2*k]   = is[k] < 0;
      w1[2*k+1] = rs[k] < 0;
    end
    for (int k = 0; k < 2; k++) begin
      w2[2*k]   = is[k+4] < 0;
      w2[2*k+1] = rs[k+4] < 0;
    end
    for (int k = 0; k < 6; k++) begin
      valid_i = 1'b1;
      mode_i  = 2'b00;
      ar      = IN_W'(rs[k]);
      ai      = IN_W'(is[k]);
      tick();
    end
    valid_i = 1'b1;
    ar = IN_W'(-500);
    ai = IN_W'(-500);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if ({ready_i, valid_o, data_o} !== {1'b0, 1'b1, w1}) begin
        errs++;
        $display("FAIL bp_hold%0d got r=%b v=%b d=%h want r=0 v=1 d=%h",
                 k, ready_i, valid_o, data_o, w1);
      end
      tick();
    end
    idle();
    ready_o = 1'b1;
    tick();
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i} !== 2'b01) begin
      errs++;
      $display("FAIL bp_release got v=%b r=%b want v=0 r=1", valid_o, ready_i);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, nbits_o, last_o} !== {1'b1, w2, 4'd4, 1'b1}) begin
      errs++;
      $display("FAIL bp_tail got v=%b d=%h n=%0d l=%b want v=1 d=%h n=4 l=1",
               valid_o, data_o, nbits_o, last_o, w2);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    valid_i = 1'b1;
    mode_i  = 2'b01;
    ar      = IN_W'(20);
    ai      = IN_W'(5);
    flush_i = 1'b1;
    tick();
    idle();
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, nbits_o, last_o, ready_i} !==
        {1'b1, 8'h01, 4'd4, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL flush_tail got v=%b d=%h n=%0d l=%b r=%b want v=1 d=01 n=4 l=1 r=0",
               valid_o, data_o, nbits_o, last_o, ready_i);
    end
    ready_o = 1'b1;
    tick();
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i, last_o} !== 3'b010) begin
      errs++;
      $display("FAIL flush_clear got v=%b r=%b l=%b want v=0 r=1 l=0",
               valid_o, ready_i, last_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i} !== 2'b00) begin
      errs++;
      $display("FAIL flush_empty got v=%b r=%b want v=0 r=0", valid_o, ready_i);
    end
    tick();
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i} !== 2'b01) begin
      errs++;
      $display("FAIL flush_empty_done got v=%b r=%b want v=0 r=1", valid_o, ready_i);
    end
  endtask

  task automatic test_reserved();
    do_reset();
    ready_o = 1'b1;
    send(2'b11, 5, 5);
    @(negedge CLK);
    checks++;
    if ({err_o, valid_o, ready_i} !== 3'b101) begin
      errs++;
      $display("FAIL rsvd_flag got e=%b v=%b r=%b want e=1 v=0 r=1",
               err_o, valid_o, ready_i);
    end
    tick();
    send(2'b01, 20, 5);
    send(2'b01, -16, -3);
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, err_o} !== {1'b1, 8'hF1, 1'b1}) begin
      errs++;
      $display("FAIL rsvd_nocnt got v=%b d=%h e=%b want v=1 d=f1 e=1",
               valid_o, data_o, err_o);
    end
    tick();
    do_reset();
    @(negedge CLK);
    checks++;
    if (err_o !== 1'b0) begin
      errs++;
      $display("FAIL rsvd_reset got e=%b want 0", err_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_o = 1'b1;
    send(2'b01, 20, 5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({valid_o, ready_i} !== 2'b01) begin
      errs++;
      $display("FAIL midrst_state got v=%b r=%b want v=0 r=1", valid_o, ready_i);
    end
    tick();
    send(2'b01, -16, -3);
    send(2'b01, 20, 5);
    @(negedge CLK);
    checks++;
    if ({valid_o, data_o, nbits_o} !== {1'b1, 8'h1F, 4'd8}) begin
      errs++;
      $display("FAIL midrst_word got v=%b d=%h n=%0d want v=1 d=1f n=8",
               valid_o, data_o, nbits_o);
    end
    tick();
  endtask

  task automatic test_random();
    int edges[21];
    int r;
    int i;
    int md;
    bit vi;
    bit fl;
    bit ro;
    bit ev;
    bit er;
    int n;
    logic [7:0] ed;
    edges = '{-49, -48, -47, -33, -32, -31, -17, -16, -15, -1, 0,
              1, 15, 16, 17, 31, 32, 33, 47, 48, 49};
    do_reset();
    mq.delete();
    mfp  = 1'b0;
    merr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      vi = $urandom_range(0, 3) != 0;
      md = ($urandom_range(0, 99) < 3) ? 3 : int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        r = edges[$urandom_range(0, 20)];
        i = edges[$urandom_range(0, 20)];
      end else begin
        r = int'($urandom_range(0, 2047)) - 1024;
        i = int'($urandom_range(0, 2047)) - 1024;
      end
      fl = $urandom_range(0, 99) < 4;
      ro = $urandom_range(0, 9) < 7;
      valid_i = vi;
      mode_i  = 2'(md);
      ar      = IN_W'(r);
      ai      = IN_W'(i);
      flush_i = fl;
      ready_o = ro;
      @(negedge CLK);
      n  = (mq.size() < OUT_W) ? mq.size() : OUT_W;
      ev = (mq.size() >= OUT_W) || (mfp && mq.size() > 0);
      er = !mfp && (mq.size() <= 2 * OUT_W - 6);
      ed = '0;
      for (int k = 0; k < n; k++) ed[k] = mq[k];
      checks++;
      if ({valid_o, ready_i, err_o} !== {ev, er, merr}) begin
        errs++;
        $display("FAIL rand_status c=%0d got v=%b r=%b e=%b want v=%b r=%b e=%b",
                 c, valid_o, ready_i, err_o, ev, er, merr);
      end
      if (ev) begin
        checks++;
        if ({data_o, nbits_o, last_o} !==
            {ed, 4'(n), mfp && mq.size() <= OUT_W}) begin
          errs++;
          $display("FAIL rand_word c=%0d got d=%h n=%0d l=%b want d=%h n=%0d l=%b",
                   c, data_o, nbits_o, last_o, ed, n,
                   mfp && mq.size() <= OUT_W);
        end
      end
      model_edge(vi, md, r, i, fl, ro, ev, er);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b1;
    tick();
    tick();
    test_reset();
    test_order();
    test_mixed();
    test_backpressure();
    test_flush();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
